systolic_ctrl: RTL and testbench

- Sequencer for an N x N weight-stationary systolic array of double-buffered-weight PEs. Each PE has a dormant/active weight pair, a `switch` input, and registered pass-through of activation (row) and weight (column).
- Per job: shift one weight tile down the columns, pulse `switch` once to promote dormant to active, stream `k_len` activation vectors with per-row skew, then drain and report completion.
- Sits between the host/tile-buffer logic and the array. Owns no datapath, only enables, indices and the swap strobe.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_ctrl_skew_pipe.sv | 23 ++
 rtl/systolic_ctrl.sv | 164 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   state_t    : controller states IDLE..DONE
//   *_DEF      : default array dimension, job length limit, MAC latency
//   drain_len  : cycles needed after the last activation until the last
//                column result has left the array
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWAP,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int N_DEF       = 4;
  localparam int K_MAX_DEF   = 256;
  localparam int MAC_LAT_DEF = 1;

  function automatic int drain_len(input int n, input int mac_lat);
    return 2 * n - 1 + mac_lat;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_pipe.sv
// skew_pipe: valid shift register with a tap per delay.
//   clk, rst : clock, asynchronous active-high reset
//   din      : valid bit entering the pipe
//   taps     : taps[i] is din delayed by i cycles (taps[0] is din itself)
module skew_pipe #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  output logic [DEPTH:0] taps
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign taps = {sr, din};

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an N x N weight-stationary systolic array.
// Loads one weight tile (deepest row first), strobes switch once, streams
// k activation vectors with per-row skew, drains, then pulses done.
//   clk, rst    : clock, asynchronous active-high reset
//   start,k_len : job request and length (sampled in IDLE, clipped to K_MAX)
//   busy, done  : job in progress / one-cycle completion pulse
//   w_load,w_row: weight word valid and tile row being driven
//   switch      : dormant->active weight promotion strobe
//   a_idx       : activation vector index being fetched
//   a_en        : per-row activation valid (row r skewed by r cycles)
//   res_valid   : per-column result valid (column c skewed by N+c+MAC_LAT)
// Optional: define SYSTOLIC_CTRL_PERF_CNT_EN to add perf_cycles, a saturating
// count of busy cycles in the most recent job.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting weight tile down the columns, N cycles
// SWAP   | single switch strobe
// STREAM | k activation vectors issued
// DRAIN  | skew pipeline flushing, 2N-1+MAC_LAT cycles
// DONE   | completion pulse
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K_MAX   = K_MAX_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int CW      = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 w_load,
  output logic [$clog2(N)-1:0] w_row,
  output logic                 switch,
  output logic [CW-1:0]        a_idx,
  output logic [N-1:0]         a_en,
  output logic [N-1:0]         res_valid
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles
`endif
);

  localparam int RW        = $clog2(N);
  localparam int DRAIN_LEN = drain_len(N, MAC_LAT);
  localparam int DEPTH     = 2 * N - 1 + MAC_LAT;

  state_t        state_q, state_d;
  logic          sv;
  logic [CW-1:0] k_q;
  logic [CW-1:0] tmr;
  logic [CW-1:0] k_sat;
  logic [DEPTH:0] taps;
  logic          unused_taps;

  assign k_sat = (k_len > CW'(K_MAX)) ? CW'(K_MAX) : k_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    w_load  = 1'b0;
    switch  = 1'b0;
    sv      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        busy   = 1'b1;
        w_load = 1'b1;
        if (w_row == '0) state_d = SWAP;
      end
      SWAP: begin
        busy   = 1'b1;
        switch = 1'b1;
        state_d = (k_q == '0) ? DONE : STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        sv   = 1'b1;
        if (tmr == '0) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (tmr == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // w_row doubles as the LOAD timer; tmr times STREAM then DRAIN.
  // a_idx is only touched entering and during STREAM so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      w_row <= '0;
      a_idx <= '0;
      tmr   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q   <= k_sat;
            w_row <= RW'(N - 1);
          end
        end
        LOAD: begin
          if (w_row != '0) w_row <= w_row - RW'(1);
        end
        SWAP: begin
          a_idx <= '0;
          tmr   <= k_q - CW'(1);
        end
        STREAM: begin
          if (tmr == '0) begin
            tmr <= CW'(DRAIN_LEN - 1);
          end else begin
            tmr   <= tmr - CW'(1);
            a_idx <= a_idx + CW'(1);
          end
        end
        DRAIN: begin
          if (tmr != '0) tmr <= tmr - CW'(1);
        end
        default: ;
      endcase
    end
  end

  skew_pipe #(.DEPTH(DEPTH)) u_skew (
    .clk  (clk),
    .rst  (rst),
    .din  (sv),
    .taps (taps)
  );

  assign a_en        = taps[N-1:0];
  assign res_valid   = taps[DEPTH -: N];
  assign unused_taps = ^taps;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           perf_cycles <= '0;
    else if (state_q == IDLE && start) perf_cycles <= '0;
    else if (busy && perf_cycles != 32'hFFFF_FFFF)
                                       perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

  localparam int N       = 4;
  localparam int K_MAX   = 256;
  localparam int MAC_LAT = 1;
  localparam int CW      = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] k_len = '0;
  logic          busy, done, w_load, switch;
  logic [1:0]    w_row;
  logic [CW-1:0] a_idx;
  logic [N-1:0]  a_en, res_valid;
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  systolic_ctrl #(.N(N), .K_MAX(K_MAX), .MAC_LAT(MAC_LAT), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .w_load    (w_load),
    .w_row     (w_row),
    .switch    (switch),
    .a_idx     (a_idx),
    .a_en      (a_en),
    .res_valid (res_valid)
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;
  int idx_q[$];
  int done_q[$];
  bit model_on = 1'b0;
  int t0 = 0;
  int jl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit sv_at(input int r);
    return (jl > 0) && (r >= N + 2) && (r <= N + 1 + jl);
  endfunction

  function automatic int done_rel();
    return (jl == 0) ? N + 2 : N + 2 + jl + 2 * N - 1 + MAC_LAT;
  endfunction

  // Per-cycle expected control waveform relative to the accept cycle, plus
  // scoreboard pops for activation indices and done pulses.
  int          r;
  logic [11:0] e_vec;
  always @(negedge clk) begin
    if (!rst) begin
      if (done === 1'b1) begin
        if (done_q.size() > 0) chk("done_cyc", cyc, done_q.pop_front());
        else                   chk("done_unexpected", 1, 0);
      end
      if (a_en[0] === 1'b1) begin
        if (idx_q.size() > 0) chk("a_idx", a_idx, idx_q.pop_front());
        else                  chk("a_idx_unexpected", 1, 0);
      end
      if (model_on) begin
        r = cyc - t0;
        e_vec[11] = (r >= 1) && (r < done_rel());
        e_vec[10] = (r == done_rel());
        e_vec[9]  = (r >= 1) && (r <= N);
        e_vec[8]  = (r == N + 1);
        for (int i = 0; i < N; i++) begin
          e_vec[4 + i] = sv_at(r - i);
          e_vec[i]     = sv_at(r - (N + i + MAC_LAT));
        end
        chk("ctl_vec", {busy, done, w_load, switch, a_en, res_valid}, e_vec);
        if (r >= 1 && r <= N) chk("w_row", w_row, N - r);
        if (r == done_rel()) begin
          if (jl > 0) chk("a_idx_hold", a_idx, jl - 1);
          model_on = 1'b0;
        end
      end
    end
  end

  task automatic launch(input int k);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = CW'(k);
    t0    = cyc;
    jl    = (k > K_MAX) ? K_MAX : k;
    for (int i = 0; i < jl; i++) idx_q.push_back(i);
    done_q.push_back(t0 + done_rel());
    model_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_job(input int budget);
    int n;
    n = 0;
    while (model_on && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (model_on) begin
      chk("job_timeout", 0, 1);
      model_on = 1'b0;
    end
  endtask

  task automatic chk_perf(input int exp);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("perf_cycles", perf_cycles, exp);
    end
`else
    repeat (3) @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, done, w_load, switch, a_en, res_valid, w_row, a_idx}, 0);
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    chk("reset_perf", perf_cycles, 0);
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // basic job, k=3: done at cycle 17, 16 busy cycles
    launch(3);
    wait_job(100);
    chk_perf(16);

    // zero length: done at cycle 6, 5 busy cycles
    launch(0);
    wait_job(50);
    chk_perf(5);

    // length clipped to K_MAX
    launch(300);
    wait_job(400);
    chk_perf(N + 1 + K_MAX + 2 * N - 1 + MAC_LAT);

    // second start during STREAM must be ignored
    launch(2);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    k_len = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_job(100);
    repeat (4) @(posedge clk);
    launch(1);
    wait_job(100);

    // async reset in cycle 7 of a k=3 job
    launch(3);
    repeat (6) @(posedge clk);
    #3;
    model_on = 1'b0;
    idx_q.delete();
    done_q.delete();
    rst = 1'b1;
    #1;
    chk("rst_async", {busy, done, w_load, switch, a_en, res_valid, w_row, a_idx}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    launch(3);
    wait_job(100);
    chk_perf(16);

    chk("sb_empty", idx_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
